clock_step_ctrl: RTL and testbench

//   Consumes the divided slow clock (SLOW_CLK) and the board buttons, and produces a
//   one-CLKI-cycle clock enable (CE) for the CPU core.

---
 rtl/clock_step_ctrl_pkg.sv | 20 ++
 rtl/btn_debounce.sv | 65 ++++++
 rtl/clock_step_ctrl.sv | 140 ++++++++++++++
 tb/tb_clock_step_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_step_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : clock_step_ctrl_pkg
// Brief   : Shared types and constants for the CPU clock-step controller.
//           cs_state_t       - controller mode (HALT / RUN / STEP)
//           DEBOUNCE_DEFAULT - 10 ms of stable samples at 100 MHz
// Rev     : 1.0  initial release
// ============================================================================
package clock_step_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_HALT = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2
   } cs_state_t;

   localparam int DEBOUNCE_DEFAULT = 1000000;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module  : btn_debounce
// Brief   : Synchronises a raw, bouncy push-button into the CLKI domain,
//           debounces it and emits a one-cycle pulse on each accepted press.
// Ports   : CLKI   in  system clock
//           RST    in  asynchronous active-high reset
//           BTN_IN in  raw button level (asynchronous, bouncy)
//           LEVEL  out debounced button level
//           PRESS  out one-cycle pulse on a 0->1 change of LEVEL
// Rev     : 1.0  initial release
// ============================================================================
module btn_debounce
   import clock_step_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int DB_W            = 20
) (
   input  logic CLKI,
   input  logic RST,
   input  logic BTN_IN,
   output logic LEVEL,
   output logic PRESS
);

   localparam logic [DB_W-1:0] c_cnt_last = DB_W'(DEBOUNCE_CYCLES - 1);

   logic            r_sync1;
   logic            r_sync2;
   logic [DB_W-1:0] r_cnt;
   logic            r_level;
   logic            r_press;

   // r_cnt measures how long the synchronised input has continuously
   // disagreed with the accepted level. Any sample agreeing with the level
   // (i.e. a bounce back) restarts the measurement.
   always_ff @(posedge CLKI or posedge RST) begin
      if (RST) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_press <= 1'b0;
      end else begin
         r_sync1 <= BTN_IN;
         r_sync2 <= r_sync1;
         r_press <= 1'b0;
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == c_cnt_last) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
            // Pulse only when the new accepted level is "pressed".
            r_press <= r_sync2;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign LEVEL = r_level;
   assign PRESS = r_press;

endmodule
`default_nettype wire

// File: rtl/clock_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : clock_step_ctrl
// Brief   : Generates the CPU clock enable from the slow divided clock and
//           the board buttons. Modes: HALT (frozen), RUN (one CE per
//           SLOW_CLK rising edge), STEP (one CE per debounced step press).
//           Also counts issued CE pulses for the display.
// Ports   : CLKI      in  system clock, 100 MHz
//           RST       in  asynchronous active-high reset
//           SLOW_CLK  in  divided clock, sampled as asynchronous data
//           BTN_RUN   in  raw run/halt toggle button
//           BTN_STEP  in  raw single-step button
//           HALT_REQ  in  CPU executed HALT; forces HALT from RUN
//           CE        out registered single-cycle CPU clock enable
//           RUNNING   out registered, high while in RUN
//           CYCLE_CNT out number of CE pulses issued (wraps)
// Rev     : 1.0  initial release
// ============================================================================
module clock_step_ctrl
   import clock_step_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int DB_W            = 20,
   parameter int CYCLE_W         = 16
) (
   input  logic               CLKI,
   input  logic               RST,
   input  logic               SLOW_CLK,
   input  logic               BTN_RUN,
   input  logic               BTN_STEP,
   input  logic               HALT_REQ,
   output logic               CE,
   output logic               RUNNING,
   output logic [CYCLE_W-1:0] CYCLE_CNT
);

   logic      w_run_press;
   logic      w_step_press;
   logic      w_unused_run_level;
   logic      w_unused_step_level;

   logic      r_slow_sync1;
   logic      r_slow_sync2;
   logic      r_slow_prev;
   logic      r_tick;

   cs_state_t r_state;
   cs_state_t w_state_next;
   logic      w_ce_next;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .DB_W            (DB_W)
   ) u_run_db (
      .CLKI   (CLKI),
      .RST    (RST),
      .BTN_IN (BTN_RUN),
      .LEVEL  (w_unused_run_level),
      .PRESS  (w_run_press)
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .DB_W            (DB_W)
   ) u_step_db (
      .CLKI   (CLKI),
      .RST    (RST),
      .BTN_IN (BTN_STEP),
      .LEVEL  (w_unused_step_level),
      .PRESS  (w_step_press)
   );

   // SLOW_CLK edge detector. The tick is registered so that CE, which is
   // itself registered from the tick, rises on the third CLKI edge after
   // the first synchroniser flop captures a high SLOW_CLK.
   always_ff @(posedge CLKI or posedge RST) begin
      if (RST) begin
         r_slow_sync1 <= 1'b0;
         r_slow_sync2 <= 1'b0;
         r_slow_prev  <= 1'b0;
         r_tick       <= 1'b0;
      end else begin
         r_slow_sync1 <= SLOW_CLK;
         r_slow_sync2 <= r_slow_sync1;
         r_slow_prev  <= r_slow_sync2;
         r_tick       <= r_slow_sync2 & ~r_slow_prev;
      end
   end

   // HALT_REQ outranks both the tick and the run button while running;
   // a step already in progress always delivers its CE.
   always_comb begin
      w_state_next = r_state;
      w_ce_next    = 1'b0;
      case (r_state)
         ST_HALT: begin
            if (w_run_press && !HALT_REQ) begin
               w_state_next = ST_RUN;
            end else if (w_step_press) begin
               w_state_next = ST_STEP;
            end
         end
         ST_STEP: begin
            w_state_next = ST_HALT;
         end
         ST_RUN: begin
            if (HALT_REQ || w_run_press) begin
               w_state_next = ST_HALT;
            end else begin
               w_ce_next = r_tick;
            end
         end
         default: begin
            w_state_next = ST_HALT;
         end
      endcase
      // The STEP state lasts one cycle and carries its own CE.
      if (w_state_next == ST_STEP) begin
         w_ce_next = 1'b1;
      end
   end

   always_ff @(posedge CLKI or posedge RST) begin
      if (RST) begin
         r_state   <= ST_HALT;
         RUNNING   <= 1'b0;
         CE        <= 1'b0;
         CYCLE_CNT <= '0;
      end else begin
         r_state <= w_state_next;
         RUNNING <= (w_state_next == ST_RUN);
         CE      <= w_ce_next;
         if (CE) begin
            CYCLE_CNT <= CYCLE_CNT + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_clock_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_clock_step_ctrl
// Brief   : Self-checking bench for clock_step_ctrl. A behavioural model
//           turns sampled inputs into expected CE events (pushed into a
//           scoreboard queue); a negedge monitor pops and compares.
// Rev     : 1.0  initial release
// ============================================================================
module tb_clock_step_ctrl;

   localparam int N_DB    = 4;
   localparam int DBW     = 3;
   localparam int CW      = 4;
   localparam int LAT     = 3;   // edges from input sample to CE edge

   logic          CLKI = 1'b0;
   logic          RST  = 1'b1;
   logic          SLOW_CLK = 1'b0;
   logic          BTN_RUN  = 1'b0;
   logic          BTN_STEP = 1'b0;
   logic          HALT_REQ = 1'b0;
   logic          CE;
   logic          RUNNING;
   logic [CW-1:0] CYCLE_CNT;

   clock_step_ctrl #(
      .DEBOUNCE_CYCLES (N_DB),
      .DB_W            (DBW),
      .CYCLE_W         (CW)
   ) dut (
      .CLKI      (CLKI),
      .RST       (RST),
      .SLOW_CLK  (SLOW_CLK),
      .BTN_RUN   (BTN_RUN),
      .BTN_STEP  (BTN_STEP),
      .HALT_REQ  (HALT_REQ),
      .CE        (CE),
      .RUNNING   (RUNNING),
      .CYCLE_CNT (CYCLE_CNT)
   );

   always #5 CLKI = ~CLKI;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int cyc;
      int cnt;
   } exp_t;

   exp_t q_exp[$];
   int   tick_due[$];
   int   runp_due[$];
   int   stepp_due[$];

   int cyc = 0;
   int mode = 0;                 // 0 halt, 1 run, 2 step
   bit slow_prev = 0;
   bit run_lvl = 0, step_lvl = 0;
   int run_len = 0, step_len = 0;
   int m_cnt = 0;
   bit prev_ce = 0;
   bit exp_running = 0;

   // A button level is accepted after N_DB consecutive samples that
   // disagree with the currently accepted level.
   task automatic db(input bit raw, input bit lvl_i, input int len_i,
                     output bit lvl_o, output int len_o, output bit fire);
      lvl_o = lvl_i;
      len_o = (raw == lvl_i) ? 0 : len_i + 1;
      fire  = 1'b0;
      if (len_o == N_DB) begin
         lvl_o = raw;
         len_o = 0;
         fire  = raw;
      end
   endtask

   always @(posedge CLKI) begin
      bit f, t, rp, sp, ce;
      if (RST) begin
         cyc = 0; mode = 0; slow_prev = 0;
         run_lvl = 0; step_lvl = 0; run_len = 0; step_len = 0;
         m_cnt = 0; prev_ce = 0; exp_running = 0;
         q_exp.delete(); tick_due.delete(); runp_due.delete(); stepp_due.delete();
      end else begin
         if (prev_ce) m_cnt = (m_cnt + 1) % (1 << CW);
         if (SLOW_CLK && !slow_prev) tick_due.push_back(cyc + LAT);
         slow_prev = SLOW_CLK;
         db(BTN_RUN, run_lvl, run_len, run_lvl, run_len, f);
         if (f) runp_due.push_back(cyc + LAT);
         db(BTN_STEP, step_lvl, step_len, step_lvl, step_len, f);
         if (f) stepp_due.push_back(cyc + LAT);

         t = 0; rp = 0; sp = 0;
         if (tick_due.size() > 0 && tick_due[0] == cyc) begin t = 1; void'(tick_due.pop_front()); end
         if (runp_due.size() > 0 && runp_due[0] == cyc) begin rp = 1; void'(runp_due.pop_front()); end
         if (stepp_due.size() > 0 && stepp_due[0] == cyc) begin sp = 1; void'(stepp_due.pop_front()); end

         ce = 0;
         if (mode == 2) begin
            mode = 0;
         end else if (mode == 1) begin
            if (HALT_REQ || rp) mode = 0;
            else ce = t;
         end else begin
            if (rp && !HALT_REQ) mode = 1;
            else if (sp) begin mode = 2; ce = 1; end
         end
         if (ce) q_exp.push_back('{cyc, m_cnt});
         prev_ce     = ce;
         exp_running = (mode == 1);
         cyc++;
      end
   end

   // ---------------- monitor ----------------
   always @(negedge CLKI) begin
      bit exp_ce;
      exp_ce = (q_exp.size() > 0 && q_exp[0].cyc == cyc - 1);
      chk("ce", int'(CE), int'(exp_ce));
      if (exp_ce) begin
         chk("cnt_at_ce", int'(CYCLE_CNT), q_exp[0].cnt);
         void'(q_exp.pop_front());
      end
      chk("running", int'(RUNNING), int'(exp_running));
      chk("cycle_cnt", int'(CYCLE_CNT), m_cnt);
   end

   // ---------------- stimulus ----------------
   task automatic cyc_n(input int n);
      repeat (n) @(negedge CLKI);
   endtask

   task automatic do_reset(input int n);
      @(negedge CLKI);
      #3 RST = 1'b1;
      repeat (n) @(negedge CLKI);
      #3 RST = 1'b0;
   endtask

   task automatic press(input bit is_run, input int hold);
      if (is_run) BTN_RUN = 1'b1; else BTN_STEP = 1'b1;
      cyc_n(hold);
      if (is_run) BTN_RUN = 1'b0; else BTN_STEP = 1'b0;
      cyc_n(8);
   endtask

   initial begin
      int bounce [7] = '{1, 1, 0, 1, 1, 1, 0};
      int phase;
      bit run_tgt, step_tgt;

      // 1. reset with SLOW_CLK toggling, then idle
      for (int i = 0; i < 5; i++) begin
         @(negedge CLKI);
         SLOW_CLK = ~SLOW_CLK;
      end
      #3 RST = 1'b0;
      for (int i = 0; i < 3; i++) begin
         SLOW_CLK = 1'b1; cyc_n(20);
         SLOW_CLK = 1'b0; cyc_n(20);
      end
      chk("idle_cnt", int'(CYCLE_CNT), 0);

      // 2. single step
      press(1'b0, 8);
      cyc_n(4);
      chk("step_cnt", int'(CYCLE_CNT), 1);
      chk("step_running", int'(RUNNING), 0);

      // 3. bouncy step button never stable for 4 samples
      for (int i = 0; i < 7; i++) begin
         BTN_STEP = bounce[i][0];
         cyc_n(1);
      end
      BTN_STEP = 1'b0;
      cyc_n(10);
      chk("bounce_cnt", int'(CYCLE_CNT), 1);

      // 4. run for 5 slow edges, then stop
      press(1'b1, 6);
      chk("run_on", int'(RUNNING), 1);
      for (int i = 0; i < 5; i++) begin
         SLOW_CLK = 1'b1; cyc_n(20);
         SLOW_CLK = 1'b0; cyc_n(20);
      end
      chk("run_cnt", int'(CYCLE_CNT), 6);
      press(1'b1, 6);
      chk("run_off", int'(RUNNING), 0);
      for (int i = 0; i < 2; i++) begin
         SLOW_CLK = 1'b1; cyc_n(20);
         SLOW_CLK = 1'b0; cyc_n(20);
      end
      chk("run_off_cnt", int'(CYCLE_CNT), 6);

      // 5. HALT_REQ on the tick cycle
      press(1'b1, 6);
      chk("run_on2", int'(RUNNING), 1);
      SLOW_CLK = 1'b1;
      cyc_n(3);
      HALT_REQ = 1'b1;
      cyc_n(1);
      chk("halt_req_running", int'(RUNNING), 0);
      cyc_n(20);
      SLOW_CLK = 1'b0;
      chk("halt_req_cnt", int'(CYCLE_CNT), 6);
      press(1'b1, 6);
      chk("run_blocked", int'(RUNNING), 0);
      press(1'b0, 6);
      chk("step_past_halt", int'(CYCLE_CNT), 7);
      HALT_REQ = 1'b0;
      cyc_n(4);

      // random phase against the model
      phase = 0; run_tgt = 0; step_tgt = 0;
      for (int i = 0; i < 3000; i++) begin
         if (++phase == 20) begin phase = 0; SLOW_CLK = ~SLOW_CLK; end
         if ($urandom_range(0, 59) == 0) run_tgt = ~run_tgt;
         if ($urandom_range(0, 29) == 0) step_tgt = ~step_tgt;
         if ($urandom_range(0, 99) == 0) HALT_REQ = ~HALT_REQ;
         BTN_RUN  = run_tgt  ^ ($urandom_range(0, 7) == 0);
         BTN_STEP = step_tgt ^ ($urandom_range(0, 7) == 0);
         cyc_n(1);
      end

      // mid-operation reset
      do_reset(3);
      BTN_RUN = 1'b0; BTN_STEP = 1'b0; HALT_REQ = 1'b0; SLOW_CLK = 1'b0;
      do_reset(3);
      cyc_n(10);
      chk("rst_cnt", int'(CYCLE_CNT), 0);
      chk("rst_running", int'(RUNNING), 0);

      // 6. wrap of the 4-bit counter
      for (int s = 1; s <= 17; s++) begin
         press(1'b0, 6);
         cyc_n(2);
         chk($sformatf("wrap_step%0d", s), int'(CYCLE_CNT), s % 16);
      end

      cyc_n(20);
      chk("ce_outstanding", q_exp.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
